// File: rtl/jacobian_pkg.sv
// Shared types and constants for the geometric Jacobian column builder.
// Fixed-point words are signed two's complement with FRAC fractional bits.
package jacobian_pkg;

  localparam int WIDTH       = 36;
  localparam int FRAC        = 27;
  localparam int MUL_LAT_DEF = 2;

  typedef logic signed [WIDTH-1:0] fx_t;
  typedef fx_t [2:0]               vec3_t;
  typedef fx_t [3:0][3:0]          mat4_t;
  typedef mat4_t [5:0]             full_mat_t;
  typedef fx_t [5:0][5:0]          jac_t;

  localparam fx_t FX_ONE  = fx_t'(1) <<< FRAC;
  localparam fx_t FX_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIFF,
    S_MUL,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/jacobian_if.sv
// Request/result bundle between the transform stage, this block
// and the Jacobian-inverse stage.
interface jacobian_if;
  import jacobian_pkg::*;

  logic      start;
  logic      busy;
  logic      done;
  full_mat_t full_matrix;
  jac_t      jacobian;

  modport master (
    output start, full_matrix,
    input  busy, done, jacobian
  );

  modport slave (
    input  start, full_matrix,
    output busy, done, jacobian
  );

endinterface

// File: rtl/jacobian_col_mult.sv
// Pipelined signed fixed-point multiply, result floor-shifted by FRAC.
// An index and valid bit travel alongside so results can be steered.
import jacobian_pkg::*;

module fx_mult #(
  parameter int LAT = 2,
  parameter int IW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [IW-1:0] idx,
  input  fx_t           a,
  input  fx_t           b,
  output logic          vld,
  output logic [IW-1:0] idx_o,
  output fx_t           p
);

  logic signed [2*WIDTH-1:0] full;
  fx_t                       p0;
  fx_t                       v  [LAT];
  logic                      ok [LAT];
  logic [IW-1:0]             ix [LAT];

  assign full = $signed({{WIDTH{a[WIDTH-1]}}, a})
              * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign p0   = fx_t'(full >>> FRAC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        v[i]  <= '0;
        ok[i] <= 1'b0;
        ix[i] <= '0;
      end
    end else begin
      v[0]  <= p0;
      ok[0] <= en;
      ix[0] <= idx;
      for (int i = 1; i < LAT; i++) begin
        v[i]  <= v[i-1];
        ok[i] <= ok[i-1];
        ix[i] <= ix[i-1];
      end
    end
  end

  assign p     = v[LAT-1];
  assign vld   = ok[LAT-1];
  assign idx_o = ix[LAT-1];

endmodule

// File: rtl/jacobian_col.sv
// Builds the 6x6 geometric Jacobian column by column from T_01..T_06,
// sharing one pipelined multiplier for all cross products.
import jacobian_pkg::*;

module jacobian_col #(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input logic       clk,
  input logic       rst,
  jacobian_if.slave bus
);

  state_e     state, state_nx;
  logic [2:0] col;
  logic [7:0] cnt;
  vec3_t      zl [5];
  vec3_t      pl [6];
  vec3_t      z, d, zs, ps;
  fx_t        prod [6];
  jac_t       jac;
  fx_t        ma, mb, mp;
  logic       mv;
  logic [2:0] mi;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_DIFF;
      S_DIFF:  state_nx = S_MUL;
      S_MUL:   if (cnt == 8'd5) state_nx = S_DRAIN;
      S_DRAIN: if (cnt == 8'(MUL_LAT-1)) state_nx = S_WRITE;
      S_WRITE: state_nx = (col == 3'd5) ? S_DONE : S_DIFF;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Column 0 uses the base frame: z=(0,0,1), origin at zero.
  always_comb begin
    zs    = '0;
    zs[2] = FX_ONE;
    ps    = '0;
    if (col != 3'd0) begin
      zs = zl[col - 3'd1];
      ps = pl[col - 3'd1];
    end
  end

  always_comb begin
    ma = FX_ZERO;
    mb = FX_ZERO;
    case (cnt[2:0])
      3'd0: begin ma = z[1]; mb = d[2]; end
      3'd1: begin ma = z[2]; mb = d[1]; end
      3'd2: begin ma = z[2]; mb = d[0]; end
      3'd3: begin ma = z[0]; mb = d[2]; end
      3'd4: begin ma = z[0]; mb = d[1]; end
      3'd5: begin ma = z[1]; mb = d[0]; end
      default: ;
    endcase
  end

  fx_mult #(.LAT(MUL_LAT), .IW(3)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .en    (state == S_MUL),
    .idx   (cnt[2:0]),
    .a     (ma),
    .b     (mb),
    .vld   (mv),
    .idx_o (mi),
    .p     (mp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      col   <= '0;
      cnt   <= '0;
      z     <= '0;
      d     <= '0;
      jac   <= '0;
      for (int k = 0; k < 6; k++) prod[k] <= '0;
      for (int k = 0; k < 5; k++) zl[k] <= '0;
      for (int k = 0; k < 6; k++) pl[k] <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_LOAD: begin
          for (int k = 0; k < 5; k++)
            for (int r = 0; r < 3; r++)
              zl[k][r] <= bus.full_matrix[k][r][2];
          for (int k = 0; k < 6; k++)
            for (int r = 0; r < 3; r++)
              pl[k][r] <= bus.full_matrix[k][r][3];
          col <= '0;
        end
        S_DIFF: begin
          z <= zs;
          for (int r = 0; r < 3; r++) d[r] <= pl[5][r] - ps[r];
          cnt <= '0;
        end
        S_MUL:   cnt <= (cnt == 8'd5) ? 8'd0 : cnt + 8'd1;
        S_DRAIN: cnt <= cnt + 8'd1;
        S_WRITE: begin
          jac[col][0] <= prod[0] - prod[1];
          jac[col][1] <= prod[2] - prod[3];
          jac[col][2] <= prod[4] - prod[5];
          jac[col][3] <= z[0];
          jac[col][4] <= z[1];
          jac[col][5] <= z[2];
          if (col != 3'd5) col <= col + 3'd1;
        end
        default: ;
      endcase
      if (mv) prod[mi] <= mp;
    end
  end

  assign bus.busy = (state == S_LOAD) || (state == S_DIFF) ||
                    (state == S_MUL) || (state == S_DRAIN) ||
                    (state == S_WRITE);
  assign bus.done     = (state == S_DONE);
  assign bus.jacobian = jac;

endmodule

// File: tb/tb_jacobian_col.sv
// Directed bench for jacobian_col: identity, planar arm, sign/truncation,
// ignored starts, mid-run reset and input stability after LOAD.
module tb_jacobian_col;
  import jacobian_pkg::*;

  localparam fx_t ONE = FX_ONE;
  localparam fx_t H   = FX_ONE / 2;
  localparam fx_t Q   = FX_ONE / 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  jacobian_if bus();

  jacobian_col #(.MUL_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_col(input string tag, input int c,
                         input fx_t e0, input fx_t e1, input fx_t e2,
                         input fx_t e3, input fx_t e4, input fx_t e5);
    fx_t e [6];
    e = '{e0, e1, e2, e3, e4, e5};
    for (int r = 0; r < 6; r++)
      chk($sformatf("%s c%0d r%0d", tag, c, r), bus.jacobian[c][r], e[r]);
  endtask

  function automatic full_mat_t ident();
    full_mat_t m;
    m = '0;
    for (int k = 0; k < 6; k++)
      for (int r = 0; r < 4; r++)
        m[k][r][r] = ONE;
    return m;
  endfunction

  task automatic scramble();
    for (int k = 0; k < 6; k++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          bus.full_matrix[k][r][c] = fx_t'({$urandom(), $urandom()});
  endtask

  // One start request, then 70 observed cycles; cycle 1 is LOAD.
  task automatic run(input string tag, input int s1, input int s2,
                     input int chg);
    int dc;
    int nd;
    int bb;
    dc = 0;
    nd = 0;
    bb = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      if (bus.done) begin
        nd++;
        if (dc == 0) dc = c;
      end
      if (bus.busy !== (c <= 61)) bb++;
      bus.start = (c == s1) || (c == s2);
      if (c == chg) scramble();
      step();
    end
    bus.start = 1'b0;
    chk({tag, " done_cycle"}, dc, 62);
    chk({tag, " done_pulses"}, nd, 1);
    chk({tag, " busy_window"}, bb, 0);
  endtask

  initial begin
    full_mat_t m;
    int nd;
    int bb;

    rst = 1'b0;
    bus.start = 1'b0;
    bus.full_matrix = ident();
    step();
    step();
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset jac", |bus.jacobian, 0);
    rst = 1'b1;
    step();

    // Identity chain: every column is pure z = (0,0,1).
    bus.full_matrix = ident();
    run("ident", 0, 0, 0);
    for (int c = 0; c < 6; c++) chk_col("ident", c, 0, 0, 0, 0, 0, ONE);

    // Planar arm with ignored start pulses while busy.
    m = ident();
    for (int k = 0; k < 6; k++) m[k][0][3] = fx_t'(k + 1) * ONE;
    bus.full_matrix = m;
    run("planar", 5, 40, 0);
    for (int c = 0; c < 6; c++)
      chk_col("planar", c, 0, fx_t'(6 - c) * ONE, 0, 0, 0, ONE);

    // Sign handling: T_01 z-axis along x, p_e = (0,-1/2,1/4).
    m = ident();
    m[0][0][2] = ONE;
    m[0][2][2] = 0;
    m[5][1][3] = -H;
    m[5][2][3] = Q;
    bus.full_matrix = m;
    run("sign", 0, 0, 0);
    chk_col("sign", 0, H, 0, 0, 0, 0, ONE);
    chk_col("sign", 1, 0, -Q, -H, ONE, 0, 0);
    chk_col("sign", 5, H, 0, 0, 0, 0, ONE);

    // Truncation toward -inf, with inputs scrambled after LOAD.
    m = ident();
    m[0][2][2] = -1;
    m[1][2][2] = 1;
    m[5][0][3] = H;
    bus.full_matrix = m;
    run("trunc", 0, 0, 3);
    chk_col("trunc", 0, 0, H, 0, 0, 0, ONE);
    chk_col("trunc", 1, 0, -1, 0, 0, 0, -1);
    chk_col("trunc", 2, 0, 0, 0, 0, 0, 1);
    chk_col("trunc", 4, 0, H, 0, 0, 0, ONE);

    // Reset in the middle of a run aborts without a done pulse.
    bus.full_matrix = ident();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 30; c++) step();
    rst = 1'b0;
    #1;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort jac", |bus.jacobian, 0);
    step();
    step();
    rst = 1'b1;
    nd = 0;
    bb = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.done) nd++;
      if (bus.busy) bb++;
      step();
    end
    chk("abort no_done", nd, 0);
    chk("abort idle", bb, 0);

    bus.full_matrix = ident();
    run("restart", 0, 0, 0);
    for (int c = 0; c < 6; c++) chk_col("restart", c, 0, 0, 0, 0, 0, ONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jacobian_col.md
Name: jacobian_col

Overview:
- Downstream consumer of the cumulative-transform stage.
- Takes the six cumulative DH transforms T_01..T_06 and builds the 6x6 geometric Jacobian one column at a time.
- Each column is [z_{i-1} x (p_e - p_{i-1}) ; z_{i-1}].
- All six columns share one pipelined signed fixed-point multiplier.
- Feeds the downstream Jacobian-inverse/transpose stage via a done pulse.

Parameters:
- WIDTH, 36: data word width, signed two's complement.
- FRAC, 27: fractional bits of the fixed-point format (ONE = 1<<FRAC).
- MUL_LAT, 2: register stages in the multiplier, from issue to result.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- full_matrix  in  6x4x4xWIDTH  cumulative transforms, indexed [k][row][col]. Element k is T_0(k+1).
- busy  out  1  high from LOAD through the final WRITE.
- done  out  1  one-cycle pulse when all six columns are written.
- jacobian  out  6x6xWIDTH  indexed [col][row]. Rows 0-2 are J_v x,y,z. Rows 3-5 are J_w x,y,z.

Behaviour:
- Reset (rst low, asynchronous): FSM goes to IDLE; busy=0, done=0, jacobian all zero; col counter, issue counter and product registers cleared. Reset mid-operation aborts the computation with no done pulse.
- FSM states and transitions:
  - IDLE: start=1 -> LOAD.
  - LOAD (1 cycle): latch full_matrix into a local copy; col=0 -> DIFF.
  - DIFF (1 cycle):
    - col 0: z=(0,0,1), p=(0,0,0).
    - col i>0: z = full_matrix[i-1][0..2][2], p = full_matrix[i-1][0..2][3].
    - Register z and d = p_e - p, where p_e = full_matrix[5][0..2][3].
    - -> MUL.
  - MUL (6 cycles): issue one product per cycle, k=0..5: zy*dz, zz*dy, zz*dx, zx*dz, zx*dy, zy*dx. -> DRAIN.
  - DRAIN (MUL_LAT cycles): capture each product into prod[k] exactly MUL_LAT cycles after its issue. -> WRITE.
  - WRITE (1 cycle):
    - jacobian[col] = {prod0-prod1, prod2-prod3, prod4-prod5, zx, zy, zz}.
    - If col==5 -> DONE; else col++ -> DIFF.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Latency: done asserts exactly 2 + 6*(8+MUL_LAT) cycles after the edge that samples start. With MUL_LAT=2 this is 62 cycles.
- Arithmetic:
  - Product = full 2*WIDTH signed product, arithmetic-shifted right by FRAC, low WIDTH bits kept. This truncates toward -inf, with no rounding and no saturation.
  - Differences wrap modulo 2^WIDTH.
- Inputs are used only via the LOAD-time latch; changes to full_matrix after LOAD have no effect.
- start while busy or in DONE is ignored; no queuing.
- jacobian holds its previous values until each column is overwritten in WRITE. Contents are only guaranteed coherent from done until the next LOAD.
- Row 3 of every transform (0,0,0,1) is never read.

Decomposition:
- Shared package jacobian_pkg holds:
  - typedefs fx_t (logic signed [WIDTH-1:0]), vec3_t, mat4_t, full_mat_t ([5:0] mat4_t), jac_t ([5:0][5:0] fx_t);
  - constants FX_ONE and FX_ZERO;
  - the FSM state enum.
- One sub-module, fx_mult: pipelined signed multiply with shift by FRAC and MUL_LAT stages. It has an enable/valid pass-through so the capture index tracks the issue index.

Test Plan:
- Identity: all six T = identity with p=0, start -> every column = (0,0,0,0,0,1)*ONE. done at cycle 62; busy high cycles 1-61.
- Planar arm: identity rotations, p_k = (k+1,0,0)*ONE -> column i = (0,(6-i),0,0,0,1)*ONE for i=0..5.
- Sign/truncation: T_01 z-axis = (ONE,0,0), p_e = (0,-ONE/2,ONE/4), other p=0 -> column 1 J_v = (0,-ONE/4,-ONE/2). Also check that a product of -1 LSB * ONE/2 truncates to -1.
- Start while busy: pulse start at cycles 5 and 40 -> exactly one done, at cycle 62; next start in IDLE runs normally.
- Reset mid-op: drop rst at cycle 30 -> busy=0, done never pulses, jacobian all zero; a restart yields the correct identity result.
- Input stability: change full_matrix to random values at cycle 3 -> the result equals the values latched at LOAD.
